// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the single-port data memory.
// Define DMEM_ARB_SPLIT_EN to service misaligned accesses as byte sequences.
package dmem_pkg;
  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HWORD = 2'd1,
    WORD  = 2'd2
  } mem_op_sz_e;
endpackage

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MemBytes = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_p0_valid,
  input  logic        i_p0_we,
  input  logic [31:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  input  mem_op_sz_e  i_p0_size,
  output logic        o_p0_ready,
  output logic [31:0] o_p0_rdata,
  output logic        o_p0_err,
  input  logic        i_p1_valid,
  input  logic        i_p1_we,
  input  logic [31:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  input  mem_op_sz_e  i_p1_size,
  output logic        o_p1_ready,
  output logic [31:0] o_p1_rdata,
  output logic        o_p1_err,
  output logic        o_mem_we,
  output logic        o_mem_re,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_data,
  output mem_op_sz_e  o_mem_size,
  input  logic [31:0] i_mem_data
);

`ifdef DMEM_ARB_SPLIT_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_SPLIT
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS
  } state_e;
`endif

  state_e      r_state;
  logic        r_prio;
  logic        r_port;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  mem_op_sz_e  r_size;

  logic        w_gnt;
  logic [2:0]  w_nbytes;
  logic [32:0] w_end;
  logic        w_oor;
  logic        w_mis;
  logic        w_reject;
  logic        w_go;
  logic        w_ready;
  logic        w_err;
  logic [31:0] w_rdata;

  // Pointer only breaks ties; a lone request always wins.
  assign w_gnt = (i_p0_valid & i_p1_valid) ? r_prio : i_p1_valid;

  always_comb begin
    w_nbytes = 3'd1;
    unique case (r_size)
      BYTE:    w_nbytes = 3'd1;
      HWORD:   w_nbytes = 3'd2;
      WORD:    w_nbytes = 3'd4;
      default: w_nbytes = 3'd1;
    endcase
  end

  // 33-bit end address so a wrap past 2^32 is out of range.
  assign w_end = {1'b0, r_addr} + {30'd0, w_nbytes} - 33'd1;
  assign w_oor = w_end >= 33'(MemBytes);
  assign w_mis = ((r_size == HWORD) & r_addr[0])
               | ((r_size == WORD) & (|r_addr[1:0]));

`ifdef DMEM_ARB_SPLIT_EN
  logic [1:0]  r_k;
  logic [31:0] r_asm;
  logic [1:0]  w_last;
  logic [4:0]  w_sh;
  logic [7:0]  w_wbyte;

  assign w_last   = 2'(w_nbytes - 3'd1);
  assign w_sh     = {r_k, 3'b000};
  assign w_wbyte  = 8'(r_wdata >> w_sh);
  assign w_reject = w_oor;
  assign w_go     = ~w_oor & ~w_mis;
`else
  assign w_reject = w_oor | w_mis;
  assign w_go     = ~w_reject;
`endif

  always_comb begin
    o_mem_we   = 1'b0;
    o_mem_re   = 1'b0;
    o_mem_addr = '0;
    o_mem_data = '0;
    o_mem_size = BYTE;
    w_ready    = 1'b0;
    w_err      = 1'b0;
    w_rdata    = '0;
    unique case (r_state)
      S_ACCESS: begin
        if (w_reject) begin
          w_ready = 1'b1;
          w_err   = 1'b1;
        end else if (w_go) begin
          o_mem_we   = r_we;
          o_mem_re   = ~r_we;
          o_mem_addr = r_addr;
          o_mem_data = r_wdata;
          o_mem_size = r_size;
          w_ready    = 1'b1;
          w_rdata    = r_we ? '0 : i_mem_data;
        end
      end
`ifdef DMEM_ARB_SPLIT_EN
      S_SPLIT: begin
        o_mem_we   = r_we;
        o_mem_re   = ~r_we;
        o_mem_addr = r_addr + {30'd0, r_k};
        o_mem_data = {24'd0, w_wbyte};
        o_mem_size = BYTE;
        if (r_k == w_last) begin
          w_ready = 1'b1;
          if (!r_we)
            w_rdata = r_asm | ({24'd0, i_mem_data[7:0]} << w_sh);
        end
      end
`endif
      default: ;
    endcase
  end

  assign o_p0_ready = w_ready & ~r_port;
  assign o_p0_err   = w_err & ~r_port;
  assign o_p0_rdata = r_port ? '0 : w_rdata;
  assign o_p1_ready = w_ready & r_port;
  assign o_p1_err   = w_err & r_port;
  assign o_p1_rdata = r_port ? w_rdata : '0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_prio  <= 1'b0;
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= BYTE;
`ifdef DMEM_ARB_SPLIT_EN
      r_k     <= '0;
      r_asm   <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_p0_valid | i_p1_valid) begin
            r_port  <= w_gnt;
            r_prio  <= ~w_gnt;
            r_we    <= w_gnt ? i_p1_we : i_p0_we;
            r_addr  <= w_gnt ? i_p1_addr : i_p0_addr;
            r_wdata <= w_gnt ? i_p1_wdata : i_p0_wdata;
            r_size  <= w_gnt ? i_p1_size : i_p0_size;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_state <= S_IDLE;
`ifdef DMEM_ARB_SPLIT_EN
          if (~w_oor & w_mis) begin
            r_state <= S_SPLIT;
            r_k     <= '0;
            r_asm   <= '0;
          end
`endif
        end
`ifdef DMEM_ARB_SPLIT_EN
        S_SPLIT: begin
          if (!r_we)
            r_asm[w_sh +: 8] <= i_mem_data[7:0];
          if (r_k == w_last)
            r_state <= S_IDLE;
          else
            r_k <= r_k + 2'd1;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: byte-array memory, reference model,
// directed scenarios followed by randomized rounds.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int MemBytes = 16;
`ifdef DMEM_ARB_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    mem_op_sz_e  size;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          chk_rd;
    int          cyc;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_p0_valid, i_p0_we, i_p1_valid, i_p1_we;
  logic [31:0] i_p0_addr, i_p0_wdata, i_p1_addr, i_p1_wdata;
  mem_op_sz_e  i_p0_size, i_p1_size;
  logic        o_p0_ready, o_p0_err, o_p1_ready, o_p1_err;
  logic [31:0] o_p0_rdata, o_p1_rdata;
  logic        o_mem_we, o_mem_re;
  logic [31:0] o_mem_addr, o_mem_data, i_mem_data;
  mem_op_sz_e  o_mem_size;

  dmem_arbiter #(.MemBytes(MemBytes)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_p0_valid(i_p0_valid), .i_p0_we(i_p0_we), .i_p0_addr(i_p0_addr),
    .i_p0_wdata(i_p0_wdata), .i_p0_size(i_p0_size),
    .o_p0_ready(o_p0_ready), .o_p0_rdata(o_p0_rdata), .o_p0_err(o_p0_err),
    .i_p1_valid(i_p1_valid), .i_p1_we(i_p1_we), .i_p1_addr(i_p1_addr),
    .i_p1_wdata(i_p1_wdata), .i_p1_size(i_p1_size),
    .o_p1_ready(o_p1_ready), .o_p1_rdata(o_p1_rdata), .o_p1_err(o_p1_err),
    .o_mem_we(o_mem_we), .o_mem_re(o_mem_re), .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data), .o_mem_size(o_mem_size), .i_mem_data(i_mem_data)
  );

  initial forever #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nstrobe = 0;
  bit mptr = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] mem [MemBytes] = '{default: 8'h00};
  logic [7:0] ref_mem [MemBytes] = '{default: 8'h00};

  function automatic int nb_of(input mem_op_sz_e s);
    return (s == BYTE) ? 1 : (s == HWORD) ? 2 : 4;
  endfunction

  // Memory: combinational read, write on the clock edge.
  always_comb begin
    i_mem_data = '0;
    for (int i = 0; i < 4; i++)
      if (i < nb_of(o_mem_size) && (longint'(o_mem_addr) + i) < MemBytes)
        i_mem_data[8*i +: 8] = mem[int'(o_mem_addr) + i];
  end

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_mem_we)
      for (int i = 0; i < nb_of(o_mem_size); i++)
        if ((longint'(o_mem_addr) + i) < MemBytes)
          mem[int'(o_mem_addr) + i] <= o_mem_data[8*i +: 8];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mon_port(input int p, input logic rdy,
                          input logic [31:0] rd, input logic er);
    exp_t e;
    int   n;
    n = (p == 0) ? q0.size() : q1.size();
    if (!rdy) begin
      chk($sformatf("p%0d_rdata_idle", p), rd, 32'h0);
      chk($sformatf("p%0d_err_idle", p), {31'd0, er}, 32'h0);
    end else if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL p%0d_unexpected_ready: got ready=1 want none", p);
    end else begin
      if (p == 0) e = q0.pop_front();
      else e = q1.pop_front();
      chk($sformatf("p%0d_err", p), {31'd0, er}, {31'd0, e.err});
      if (e.chk_rd) chk($sformatf("p%0d_rdata", p), rd, e.rdata);
      chk($sformatf("p%0d_ready_cycle", p), cyc, e.cyc);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst) begin
      if (o_mem_we || o_mem_re) begin
        nstrobe++;
        chk("mem_addr_in_range", {31'd0, o_mem_addr < MemBytes}, 32'h1);
      end
      mon_port(0, o_p0_ready, o_p0_rdata, o_p0_err);
      mon_port(1, o_p1_ready, o_p1_rdata, o_p1_err);
    end
  end

  // Reference: a request's outcome from the range/alignment rules alone.
  task automatic model(input req_t r, output exp_t e,
                       output int s, output int lat);
    int nb;
    bit oor, mis;
    nb  = nb_of(r.size);
    oor = (longint'(r.addr) + nb - 1) >= MemBytes;
    mis = (r.addr % nb) != 0;
    e.rdata  = '0;
    e.err    = 1'b0;
    e.chk_rd = 1'b1;
    e.cyc    = 0;
    if (oor || (mis && !SPLIT)) begin
      e.err = 1'b1;
      s     = 0;
      lat   = 1;
    end else begin
      for (int i = 0; i < nb; i++)
        if (r.we) ref_mem[int'(r.addr) + i] = r.wdata[8*i +: 8];
        else e.rdata |= 32'(ref_mem[int'(r.addr) + i]) << (8 * i);
      s        = mis ? nb : 1;
      lat      = mis ? 1 + nb : 1;
      e.chk_rd = !(r.we && mis);
    end
  endtask

  function automatic req_t mk(input bit we, input logic [31:0] a,
                              input logic [31:0] d, input mem_op_sz_e sz);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d; r.size = sz;
    return r;
  endfunction

  task automatic run_round(input bit v0, input req_t r0,
                           input bit v1, input req_t r1, input bit drop);
    exp_t e;
    int   s, lat, t, tot;
    bit   first, p, pend0, pend1;
    pend0 = v0;
    pend1 = v1;
    first = (v0 && v1) ? mptr : v1;
    t     = cyc;
    tot   = 0;
    for (int j = 0; j < 2; j++) begin
      p = (j == 0) ? first : !first;
      if (p ? v1 : v0) begin
        model(p ? r1 : r0, e, s, lat);
        if (j == 1) t = t + 1;
        t     = t + lat;
        e.cyc = t;
        if (p) q1.push_back(e);
        else q0.push_back(e);
        tot  += s;
        mptr  = !p;
      end
    end
    nstrobe    = 0;
    i_p0_valid = v0; i_p0_we = r0.we; i_p0_addr = r0.addr;
    i_p0_wdata = r0.wdata; i_p0_size = r0.size;
    i_p1_valid = v1; i_p1_we = r1.we; i_p1_addr = r1.addr;
    i_p1_wdata = r1.wdata; i_p1_size = r1.size;
    for (int k = 0; k < 60 && (pend0 || pend1); k++) begin
      @(negedge i_clk);
      if (o_p0_ready) begin pend0 = 0; i_p0_valid = 0; end
      if (o_p1_ready) begin pend1 = 0; i_p1_valid = 0; end
      if (drop && k == 0 && !(v0 && v1)) begin
        i_p0_valid = 0;
        i_p1_valid = 0;
      end
    end
    if (pend0 || pend1) begin
      checks++;
      errors++;
      $display("FAIL round_timeout: got pending=%0b%0b want 00", pend1, pend0);
      q0.delete();
      q1.delete();
      i_p0_valid = 0;
      i_p1_valid = 0;
    end
    repeat (2) @(negedge i_clk);
    chk("strobe_count", nstrobe, tot);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_p0_ready"}, {31'd0, o_p0_ready}, 0);
    chk({tag, "_p0_rdata"}, o_p0_rdata, 0);
    chk({tag, "_p0_err"}, {31'd0, o_p0_err}, 0);
    chk({tag, "_p1_ready"}, {31'd0, o_p1_ready}, 0);
    chk({tag, "_p1_rdata"}, o_p1_rdata, 0);
    chk({tag, "_p1_err"}, {31'd0, o_p1_err}, 0);
    chk({tag, "_mem_we"}, {31'd0, o_mem_we}, 0);
    chk({tag, "_mem_re"}, {31'd0, o_mem_re}, 0);
    chk({tag, "_mem_addr"}, o_mem_addr, 0);
    chk({tag, "_mem_data"}, o_mem_data, 0);
    chk({tag, "_mem_size"}, {30'd0, o_mem_size}, {30'd0, BYTE});
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.we    = 1'($urandom % 2);
    r.size  = mem_op_sz_e'($urandom_range(0, 2));
    r.wdata = $urandom;
    if ($urandom % 8 == 0) r.addr = 32'hFFFF_FFFC + ($urandom % 4);
    else r.addr = $urandom_range(0, MemBytes + 1);
    return r;
  endfunction

  req_t nul, rq0, rq1;

  initial begin
    nul = mk(0, 0, 0, BYTE);
    i_rst = 0;
    i_p0_valid = 0; i_p0_we = 0; i_p0_addr = 0; i_p0_wdata = 0;
    i_p0_size = BYTE;
    i_p1_valid = 0; i_p1_we = 0; i_p1_addr = 0; i_p1_wdata = 0;
    i_p1_size = BYTE;
    repeat (3) @(negedge i_clk);
    chk_zero("reset");
    i_rst = 1;
    repeat (2) @(negedge i_clk);

    // Both ports contending: grants alternate 0,1,0,1.
    run_round(1, mk(1, 0, 32'h12, BYTE), 1, mk(1, 1, 32'h34, BYTE), 0);
    run_round(1, mk(0, 1, 0, BYTE), 1, mk(0, 0, 0, BYTE), 0);

    run_round(1, mk(1, 8, 32'hDEAD_BEEF, WORD), 0, nul, 0);
    run_round(1, mk(0, 8, 0, WORD), 0, nul, 0);

    run_round(1, mk(1, 5, 32'h11, BYTE), 0, nul, 0);
    run_round(1, mk(1, 6, 32'h22, BYTE), 0, nul, 0);
    run_round(1, mk(1, 7, 32'h33, BYTE), 0, nul, 0);
    run_round(1, mk(1, 8, 32'h44, BYTE), 0, nul, 0);
    run_round(0, nul, 1, mk(0, 5, 0, WORD), 0);

    run_round(1, mk(1, 14, 32'hAAAA_AAAA, WORD), 0, nul, 0);
    run_round(1, mk(1, 32'hFFFF_FFFE, 32'hBBBB_BBBB, WORD), 0, nul, 0);

    run_round(1, mk(1, 0, 32'hA5, BYTE), 0, nul, 0);
    run_round(1, mk(1, 1, 32'h5A, BYTE), 0, nul, 0);
    run_round(1, mk(0, 0, 0, HWORD), 0, nul, 0);

    // Reset mid-transaction (second byte of a split store when enabled).
    rq0 = mk(1, SPLIT ? 32'd1 : 32'd0, 32'hCAFE_F00D, WORD);
    i_p0_valid = 1; i_p0_we = rq0.we; i_p0_addr = rq0.addr;
    i_p0_wdata = rq0.wdata; i_p0_size = rq0.size;
    repeat (SPLIT ? 3 : 1) @(negedge i_clk);
    chk("pre_reset_mem_we", {31'd0, o_mem_we}, 32'h1);
    i_rst = 0;
    #1;
    chk_zero("midreset");
    i_p0_valid = 0;
    @(negedge i_clk);
    i_rst = 1;
    if (SPLIT) ref_mem[1] = 8'h0D;
    mptr = 0;
    repeat (2) @(negedge i_clk);
    run_round(1, mk(0, 0, 0, WORD), 1, mk(0, 4, 0, WORD), 0);

    for (int n = 0; n < 150; n++) begin
      bit v0, v1;
      v0  = 1'($urandom % 2);
      v1  = 1'($urandom % 2);
      if (!v0 && !v1) v0 = 1;
      rq0 = rnd_req();
      rq1 = rnd_req();
      run_round(v0, rq0, v1, rq1, ($urandom % 4) == 0);
    end

    for (int i = 0; i < MemBytes; i++)
      chk($sformatf("mem_byte_%0d", i), {24'd0, mem[i]}, {24'd0, ref_mem[i]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port data memory. It shares the memory between the core load/store unit (port 0) and the debug/DMA master (port 1) using round-robin arbitration. It checks address range and alignment, and optionally splits misaligned halfword/word accesses into sequential byte accesses. It sits between the requesters and the memory's `we/re/addr/data/size` port; memory read data is combinational and writes commit on the clock edge.

## Interface
- `MemBytes`, default 16: total memory size in bytes; valid byte addresses are 0..MemBytes-1.
- `i_clk`  in  1: clock.
- `i_rst`  in  1: reset, asynchronous, active-low.
- `i_pN_valid`  in  1: request from port N (N = 0, 1); held with its fields until `o_pN_ready`.
- `i_pN_we`  in  1: 1 = store, 0 = load.
- `i_pN_addr`  in  32: byte address.
- `i_pN_wdata`  in  32: store data, right-aligned.
- `i_pN_size`  in  `mem_op_sz_e`: BYTE / HWORD / WORD.
- `o_pN_ready`  out  1: one-cycle completion pulse.
- `o_pN_rdata`  out  32: load data, zero-extended; valid only while `o_pN_ready`=1, otherwise 0.
- `o_pN_err`  out  1: valid with `o_pN_ready`; access rejected, no memory side effect.
- `o_mem_we`, `o_mem_re`  out  1: memory strobes.
- `o_mem_addr`  out  32, `o_mem_data`  out  32, `o_mem_size`  out  `mem_op_sz_e`: memory command.
- `i_mem_data`  in  32: combinational memory read data.

## Operation
- States: IDLE, ACCESS, SPLIT.
- **IDLE**
  - Memory strobes are 0.
  - If any `i_pN_valid`=1, pick the winner, latch its request (we, addr, wdata, size, port id) and go to ACCESS.
- **Arbitration**
  - Round-robin with a 1-bit priority pointer; reset value favours port 0.
  - A lone request wins regardless of the pointer.
  - After a grant, the pointer moves to the other port.
- **Range and alignment checks** (on the latched request, in ACCESS)
  - Out of range: addr + bytes(size) - 1 >= MemBytes, computed in 33 bits so wrap-around past 2^32 counts as out of range.
  - Misaligned: HWORD with addr[0]=1, or WORD with addr[1:0]≠0.
- **ACCESS** (exactly one of the following, then back to IDLE)
  - Out of range: no strobe; `ready`=1, `err`=1, `rdata`=0.
  - Misaligned with split disabled: no strobe; `ready`=1, `err`=1, `rdata`=0.
  - Misaligned with split enabled: go to SPLIT with byte index k=0; no strobe in this cycle.
  - Otherwise: drive `o_mem_re` = !we, `o_mem_we` = we, plus addr, wdata and size. `ready`=1 with `rdata` = `i_mem_data` for loads and 0 for stores.
- **SPLIT**
  - One BYTE access per cycle at addr+k, k = 0..n-1 (n = 2 or 4).
  - Write data for each access is wdata byte k in bits [7:0].
  - Loads capture `i_mem_data[7:0]` into byte k of a 32-bit assembly register.
  - On k = n-1: `ready`=1, `rdata` = assembled value (the last byte taken directly from `i_mem_data`), `err`=0; return to IDLE.
- **Requester misbehaviour**: if the requester drops `valid` mid-transaction, the transaction still completes and the `ready` pulse is still emitted.
- **Reset (any time, including mid-SPLIT)**
  - State returns to IDLE, pointer to port 0, assembly register to 0.
  - All outputs go to 0 immediately (`o_mem_size` = BYTE).
  - Partially written split stores stay partially written.

## Timing
- Memory-side outputs come from state and latched registers only; there is no combinational path from `i_pN_*` to `o_mem_*`.
- `valid` sampled in IDLE at edge T → memory access and `ready` in cycle T+1.
  - Aligned or rejected requests take 2 cycles.
  - Split requests take 2+n cycles (4 for HWORD, 6 for WORD).
- Store data is in memory after the edge that closes the `ready` cycle.
- Throughput: one request per 2 cycles at best, since IDLE always takes one cycle.
- The losing port waits at least 2 cycles; it is guaranteed service after one winning transaction.

## Configuration
- `DMEM_ARB_SPLIT_EN` defined: SPLIT state present; misaligned accesses are serviced as byte sequences and return `err`=0.
- `DMEM_ARB_SPLIT_EN` undefined: no SPLIT state or assembly register; misaligned accesses return `err`=1 in 2 cycles with no memory access.

## Test plan
- Port 0 WORD store 0xDEADBEEF at addr 8, then WORD load at addr 8 → `o_p0_ready` on cycle 2 of each; load `rdata` = 0xDEADBEEF, `err`=0.
- Both ports hold `valid` continuously for 4 transactions after reset → grant order 0,1,0,1; each `ready` pulse exactly one cycle.
- Bytes 5..8 preloaded with 0x11, 0x22, 0x33, 0x44; port 1 WORD load at addr 5:
  - With `DMEM_ARB_SPLIT_EN`: 4 byte reads, `rdata` = 0x44332211 on cycle 6.
  - Without it: `err`=1 on cycle 2 and `o_mem_re` never asserted.
- MemBytes=16, WORD store at addr 14, then at addr 0xFFFFFFFE → `err`=1 both times, `o_mem_we` never asserted, memory unchanged.
- Assert `i_rst` during the second byte of a split WORD store → all outputs 0 immediately; after release, a port 1 request (port 0 also valid) is granted to port 0 first.
- HWORD load at addr 0 with memory holding 0xA5 at byte 0 and 0x5A at byte 1 → `rdata` = 0x00005AA5.
